// File: rtl/char_scan_buff.sv
// char_scan_buff: buffers a "process n chars" byte stream in on-chip RAM, then
// slides a STR_LEN-byte window across it. Each window is sent to the md5 engine
// and the returned digest is compared against the target hash.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   proc_start            begin a new job, latch proc_num_bytes
//   proc_num_bytes        job length in bytes (clamped to buffer depth)
//   proc_data(_valid)     incoming stream bytes
//   proc_target_hash      digest to match
//   proc_match_char_next  advance the matched-string readout index
//   proc_done/match       job finished / match found (held until restart)
//   proc_byte_pos         first byte position of the matching window
//   proc_match_char       current byte of the window register
//   hash_start/msg        request to the md5 engine (msg MSBs = first byte)
//   hash_ready/valid      engine idle / digest valid
//   hash_digest           md5 result
module char_scan_buff #(
    parameter int unsigned STR_LEN    = 19,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 proc_start,
    input  logic [15:0]          proc_num_bytes,
    input  logic [7:0]           proc_data,
    input  logic                 proc_data_valid,
    input  logic [127:0]         proc_target_hash,
    input  logic                 proc_match_char_next,
    output logic                 proc_done,
    output logic                 proc_match,
    output logic [15:0]          proc_byte_pos,
    output logic [7:0]           proc_match_char,
    output logic                 hash_start,
    output logic [8*STR_LEN-1:0] hash_msg,
    input  logic                 hash_ready,
    input  logic                 hash_valid,
    input  logic [127:0]         hash_digest
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned WIN_W = 8 * STR_LEN;
    localparam int unsigned CNT_W = $clog2(STR_LEN + 1);
    localparam int unsigned IDX_W = $clog2(STR_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FILL, S_ISSUE, S_WAIT, S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [15:0]             n;
    logic [15:0]             wr_ptr;
    logic [15:0]             pos;
    logic [CNT_W-1:0]        fill_cnt;
    logic [IDX_W-1:0]        rd_idx;
    logic [WIN_W-1:0]        window;
    logic [7:0]              mem [DEPTH];
    logic [7:0]              rd_data;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    wr_en;
    logic                    digest_eq;
    logic                    last_win;

    assign rd_addr   = ADDR_WIDTH'(pos) + ADDR_WIDTH'(fill_cnt);
    assign wr_en     = (state == S_LOAD) && proc_data_valid && (wr_ptr != n) && !proc_start;
    assign digest_eq = (hash_digest == proc_target_hash);
    assign last_win  = (17'(pos) + 17'(STR_LEN)) == 17'(n);
    assign hash_msg  = window;

    // Buffer RAM: one write port in LOAD, registered read (1-cycle latency).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ADDR_WIDTH'(wr_ptr)] <= proc_data;
        end
        rd_data <= mem[rd_addr];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; proc_start overrides every state.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_IDLE;
            S_LOAD:  if (wr_ptr == n) state_next = (n < 16'(STR_LEN)) ? S_DONE : S_FILL;
            S_FILL:  if (fill_cnt == CNT_W'(STR_LEN)) state_next = S_ISSUE;
            S_ISSUE: if (hash_ready) state_next = S_WAIT;
            S_WAIT:  if (hash_valid) state_next = (digest_eq || last_win) ? S_DONE : S_FILL;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
        if (proc_start) begin
            state_next = S_LOAD;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            n             <= '0;
            wr_ptr        <= '0;
            pos           <= '0;
            fill_cnt      <= '0;
            rd_idx        <= '0;
            window        <= '0;
            proc_done     <= 1'b0;
            proc_match    <= 1'b0;
            proc_byte_pos <= '0;
            hash_start    <= 1'b0;
        end else begin
            hash_start <= 1'b0;
            proc_done  <= (state_next == S_DONE);
            if (proc_start) begin
                n             <= ({1'b0, proc_num_bytes} > 17'(DEPTH)) ? 16'(DEPTH) : proc_num_bytes;
                wr_ptr        <= '0;
                pos           <= '0;
                fill_cnt      <= '0;
                rd_idx        <= '0;
                proc_match    <= 1'b0;
                proc_byte_pos <= '0;
            end else begin
                if (proc_match_char_next) begin
                    rd_idx <= (rd_idx == IDX_W'(STR_LEN - 1)) ? '0 : rd_idx + IDX_W'(1);
                end
                case (state)
                    S_LOAD: begin
                        if (wr_en) wr_ptr <= wr_ptr + 16'd1;
                        if (wr_ptr == n) begin
                            pos      <= '0;
                            fill_cnt <= '0;
                        end
                    end
                    S_FILL: begin
                        // rd_data lags the address by one cycle, so shift from count 1 on.
                        if (fill_cnt != '0) window <= {window[WIN_W-9:0], rd_data};
                        fill_cnt <= (fill_cnt == CNT_W'(STR_LEN)) ? '0 : fill_cnt + CNT_W'(1);
                    end
                    S_ISSUE: begin
                        if (hash_ready) hash_start <= 1'b1;
                    end
                    S_WAIT: begin
                        if (hash_valid) begin
                            if (digest_eq) begin
                                proc_byte_pos <= pos;
                                proc_match    <= 1'b1;
                            end else if (!last_win) begin
                                pos <= pos + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Matched-string readout: rd_idx 0 selects the MSB byte of the window.
    always_comb begin
        proc_match_char = 8'h00;
        for (int i = 0; i < int'(STR_LEN); i++) begin
            if (rd_idx == IDX_W'(i)) proc_match_char = window[8*(int'(STR_LEN)-1-i) +: 8];
        end
    end

endmodule

// File: tb/tb_char_scan_buff.sv
// Scoreboard bench for char_scan_buff: stimulus pushes expected hash messages
// and job results; monitor pops and compares when the DUT presents them.
module tb_char_scan_buff;

    localparam int unsigned STR_LEN = 19;
    localparam int unsigned WIN_W   = 8 * STR_LEN;

    typedef struct {
        logic        match;
        logic [15:0] pos;
    } done_t;

    logic              clk;
    logic              reset;
    logic              proc_start;
    logic [15:0]       proc_num_bytes;
    logic [7:0]        proc_data;
    logic              proc_data_valid;
    logic [127:0]      proc_target_hash;
    logic              proc_match_char_next;
    logic              proc_done;
    logic              proc_match;
    logic [15:0]       proc_byte_pos;
    logic [7:0]        proc_match_char;
    logic              hash_start;
    logic [WIN_W-1:0]  hash_msg;
    logic              hash_ready;
    logic              hash_valid;
    logic [127:0]      hash_digest;

    logic              eng_valid;
    logic [127:0]      eng_digest;
    logic              stale_valid;
    logic [127:0]      stale_digest;
    logic              engine_en;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    logic [WIN_W-1:0] exp_msg[$];
    done_t            exp_done[$];

    assign hash_valid  = eng_valid | stale_valid;
    assign hash_digest = stale_valid ? stale_digest : eng_digest;

    char_scan_buff #(.STR_LEN(STR_LEN), .ADDR_WIDTH(11)) dut (
        .clk(clk), .reset(reset),
        .proc_start(proc_start), .proc_num_bytes(proc_num_bytes),
        .proc_data(proc_data), .proc_data_valid(proc_data_valid),
        .proc_target_hash(proc_target_hash), .proc_match_char_next(proc_match_char_next),
        .proc_done(proc_done), .proc_match(proc_match),
        .proc_byte_pos(proc_byte_pos), .proc_match_char(proc_match_char),
        .hash_start(hash_start), .hash_msg(hash_msg),
        .hash_ready(hash_ready), .hash_valid(hash_valid), .hash_digest(hash_digest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] dig(input logic [WIN_W-1:0] m);
        return m[WIN_W-1:24] ^ {8{m[15:0]}};
    endfunction

    function automatic logic [7:0] sbyte(input int idx, input logic [7:0] base);
        return base + 8'(idx % 26);
    endfunction

    function automatic logic [WIN_W-1:0] make_win(input int start, input logic [7:0] base);
        logic [WIN_W-1:0] w = '0;
        for (int k = 0; k < int'(STR_LEN); k++) w = {w[WIN_W-9:0], sbyte(start + k, base)};
        return w;
    endfunction

    // Engine model: digest returned 3 cycles after hash_start.
    initial begin
        logic [WIN_W-1:0] m;
        eng_valid = 1'b0;
        eng_digest = '0;
        forever begin
            @(negedge clk);
            if (hash_start && engine_en) begin
                m = hash_msg;
                repeat (3) @(posedge clk);
                #1;
                eng_valid = 1'b1;
                eng_digest = dig(m);
                @(posedge clk);
                #1;
                eng_valid = 1'b0;
            end
        end
    end

    // Monitor: pops expectations on hash_start and on proc_done rising.
    initial begin
        logic  done_q;
        done_t d;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (hash_start) begin
                    hs_count++;
                    if (exp_msg.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_hash_start: got msg %0h expected no request", hash_msg);
                    end else begin
                        check("hash_msg", hash_msg, exp_msg.pop_front());
                    end
                end
                if (proc_done && !done_q) begin
                    if (exp_done.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got proc_done=1 expected none");
                    end else begin
                        d = exp_done.pop_front();
                        check("done_match", WIN_W'(proc_match), WIN_W'(d.match));
                        check("done_byte_pos", WIN_W'(proc_byte_pos), WIN_W'(d.pos));
                    end
                end
            end
            done_q = proc_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [15:0] nb, input logic [127:0] tgt);
        proc_target_hash = tgt;
        proc_num_bytes = nb;
        proc_start = 1'b1;
        tick();
        proc_start = 1'b0;
    endtask

    task automatic stream(input int cnt, input logic [7:0] base);
        for (int i = 0; i < cnt; i++) begin
            proc_data = sbyte(i, base);
            proc_data_valid = 1'b1;
            tick();
        end
        proc_data_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (!proc_done && cyc < 3000) begin
            tick();
            cyc++;
        end
        if (!proc_done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got proc_done=0 expected 1 within 3000 cycles", name);
        end
        tick();
        tick();
    endtask

    initial begin
        int hs0;
        int cyc;
        logic [127:0] tgt;
        reset = 1'b1;
        proc_start = 1'b0;
        proc_num_bytes = '0;
        proc_data = '0;
        proc_data_valid = 1'b0;
        proc_target_hash = '0;
        proc_match_char_next = 1'b0;
        hash_ready = 1'b1;
        stale_valid = 1'b0;
        stale_digest = '0;
        engine_en = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state and idle
        repeat (10) tick();
        check("rst_done", WIN_W'(proc_done), '0);
        check("rst_match", WIN_W'(proc_match), '0);
        check("rst_byte_pos", WIN_W'(proc_byte_pos), '0);
        check("rst_match_char", WIN_W'(proc_match_char), '0);
        check("rst_hash_start", WIN_W'(hash_start), '0);
        check("rst_hash_msg", hash_msg, '0);
        check("rst_hs_count", WIN_W'(hs_count), '0);

        // Match at window 7 of a 40-byte stream
        for (int p = 0; p <= 7; p++) exp_msg.push_back(make_win(p, 8'h61));
        exp_done.push_back('{match: 1'b1, pos: 16'd7});
        hs0 = hs_count;
        start_job(16'd40, dig(make_win(7, 8'h61)));
        stream(40, 8'h61);
        wait_done("match40");
        check("match40_hs", WIN_W'(hs_count - hs0), WIN_W'(8));
        check("match40_q", WIN_W'(exp_msg.size()), '0);
        check("match40_pos", WIN_W'(proc_byte_pos), WIN_W'(7));

        // Readout of matched string, with wrap
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("match_char_%0d", i), WIN_W'(proc_match_char), WIN_W'(sbyte(7 + (i % 19), 8'h61)));
            @(posedge clk);
            #1;
            proc_match_char_next = 1'b1;
            tick();
            proc_match_char_next = 1'b0;
        end

        // No match across all 22 windows
        for (int p = 0; p <= 21; p++) exp_msg.push_back(make_win(p, 8'h61));
        exp_done.push_back('{match: 1'b0, pos: 16'd0});
        hs0 = hs_count;
        start_job(16'd40, 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978);
        stream(40, 8'h61);
        wait_done("nomatch40");
        check("nomatch40_hs", WIN_W'(hs_count - hs0), WIN_W'(22));
        check("nomatch40_match", WIN_W'(proc_match), '0);

        // Short job: fewer bytes than a window
        exp_done.push_back('{match: 1'b0, pos: 16'd0});
        hs0 = hs_count;
        start_job(16'd10, 128'h1);
        stream(10, 8'h61);
        wait_done("short10");
        check("short10_hs", WIN_W'(hs_count - hs0), '0);

        // Empty job: done on the cycle after proc_start
        exp_done.push_back('{match: 1'b0, pos: 16'd0});
        start_job(16'd0, 128'h1);
        check("zero_done_early", WIN_W'(proc_done), '0);
        tick();
        check("zero_done", WIN_W'(proc_done), WIN_W'(1));
        tick();

        // Restart mid-WAIT; stale digest equal to the new target must be ignored
        engine_en = 1'b0;
        exp_msg.push_back(make_win(0, 8'h61));
        hs0 = hs_count;
        start_job(16'd40, 128'h1111);
        stream(40, 8'h61);
        cyc = 0;
        while (hs_count == hs0 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("abort_first_hs", WIN_W'(hs_count - hs0), WIN_W'(1));
        tick();
        tick();
        tgt = 128'hcafe_f00d_0000_1111_2222_3333_4444_5555;
        exp_msg.push_back(make_win(0, 8'h41));
        exp_done.push_back('{match: 1'b0, pos: 16'd0});
        engine_en = 1'b1;
        hs0 = hs_count;
        start_job(16'd19, tgt);
        stale_digest = tgt;
        stale_valid = 1'b1;
        tick();
        stale_valid = 1'b0;
        stream(19, 8'h41);
        wait_done("restart19");
        check("restart19_hs", WIN_W'(hs_count - hs0), WIN_W'(1));
        check("restart19_match", WIN_W'(proc_match), '0);

        // hash_ready held low delays the request
        hash_ready = 1'b0;
        exp_done.push_back('{match: 1'b1, pos: 16'd0});
        hs0 = hs_count;
        start_job(16'd19, dig(make_win(0, 8'h41)));
        stream(19, 8'h41);
        repeat (50) tick();
        check("ready_hold_hs", WIN_W'(hs_count - hs0), '0);
        check("ready_hold_done", WIN_W'(proc_done), '0);
        exp_msg.push_back(make_win(0, 8'h41));
        hash_ready = 1'b1;
        wait_done("ready19");
        check("ready19_hs", WIN_W'(hs_count - hs0), WIN_W'(1));
        check("ready19_q", WIN_W'(exp_done.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
